// File: rtl/fft_mag_peak_if.sv
// FFT source stream, spectrum read port and peak-result bundle for fft_mag_peak.
// slave = the peak finder; master = whatever feeds the FFT samples and reads results.
interface fft_mag_peak_if #(
   parameter int NPTS = 1024,
   parameter int DW   = 8
);
   localparam int AW = $clog2(NPTS);

   logic                 src_valid;
   logic                 src_sop;
   logic                 src_eop;
   logic signed [DW-1:0] src_real;
   logic signed [DW-1:0] src_imag;
   logic                 src_ready;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [DW:0]          rd_data;
   logic                 rd_valid;
   logic [AW-1:0]        peak_bin;
   logic [DW:0]          peak_mag;
   logic                 frame_done;
   logic                 frame_err;

   modport slave (
      input  src_valid, src_sop, src_eop, src_real, src_imag, rd_en, rd_addr,
      output src_ready, rd_data, rd_valid, peak_bin, peak_mag, frame_done, frame_err
   );

   modport master (
      output src_valid, src_sop, src_eop, src_real, src_imag, rd_en, rd_addr,
      input  src_ready, rd_data, rd_valid, peak_bin, peak_mag, frame_done, frame_err
   );
endinterface

// File: rtl/fft_mag_peak.sv
// L1 magnitude spectrum capture and peak search; buffer write 2 cycles after a beat, frame_done 3 cycles after eop.
// Backpressure: src_ready drops only for the 2 drain cycles after a complete frame; reads answer the next cycle.
module fft_mag_peak #(
   parameter int NPTS    = 1024,
   parameter int DW      = 8,
   parameter bit SKIP_DC = 1'b1
) (
   input  logic         Clk,
   input  logic         Reset_n,
   fft_mag_peak_if.slave bus
);
   localparam int AW   = $clog2(NPTS);
   localparam int HALF = NPTS / 2;
   localparam logic [AW-1:0] LAST_BIN  = AW'(NPTS - 1);
   localparam logic [AW-1:0] PEAK_INIT = SKIP_DC ? AW'(1) : '0;

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t        state;
   logic [AW-1:0] bin_cnt;
   logic          drain_cnt;

   logic          accept;
   logic          frame_start;
   logic [AW-1:0] in_bin;

   logic          s1_vld;
   logic [AW-1:0] s1_bin;
   logic [DW-1:0] s1_re_abs;
   logic [DW-1:0] s1_im_abs;
   logic [DW:0]   mag;
   logic          stored;
   logic          peak_hit;

   logic [DW:0]   run_mag;
   logic [AW-1:0] run_bin;

   logic [DW:0]   mem [HALF];

   function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x);
      // two's-complement negate in DW bits maps -2^(DW-1) onto +2^(DW-1) unsigned
      return x[DW-1] ? (~x + 1'b1) : x;
   endfunction

   assign accept      = bus.src_valid & bus.src_ready;
   assign frame_start = accept & bus.src_sop;
   assign in_bin      = (state == CAPTURE && !bus.src_sop) ? bin_cnt : '0;

   assign mag      = {1'b0, s1_re_abs} + {1'b0, s1_im_abs};
   assign stored   = ~s1_bin[AW-1];
   assign peak_hit = s1_vld && stored && !(SKIP_DC && s1_bin == '0) && (mag > run_mag);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= IDLE;
         bin_cnt        <= '0;
         drain_cnt      <= 1'b0;
         bus.src_ready  <= 1'b1;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.peak_bin   <= '0;
         bus.peak_mag   <= '0;
      end else begin
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state   <= CAPTURE;
                  bin_cnt <= AW'(1);
               end
            end
            CAPTURE: begin
               if (accept) begin
                  if (bus.src_sop) begin
                     bus.frame_err <= 1'b1;
                     bin_cnt       <= AW'(1);
                  end else if (bin_cnt == LAST_BIN) begin
                     if (bus.src_eop) begin
                        state         <= DRAIN;
                        drain_cnt     <= 1'b0;
                        bus.src_ready <= 1'b0;
                     end else begin
                        state         <= IDLE;
                        bus.frame_err <= 1'b1;
                     end
                  end else if (bus.src_eop) begin
                     state         <= IDLE;
                     bus.frame_err <= 1'b1;
                  end else begin
                     bin_cnt <= bin_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state          <= IDLE;
                  bus.src_ready  <= 1'b1;
                  bus.frame_done <= 1'b1;
                  bus.peak_bin   <= run_bin;
                  bus.peak_mag   <= run_mag;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_vld    <= 1'b0;
         s1_bin    <= '0;
         s1_re_abs <= '0;
         s1_im_abs <= '0;
      end else begin
         s1_vld    <= accept && (state == CAPTURE || bus.src_sop);
         s1_bin    <= in_bin;
         s1_re_abs <= abs_val(bus.src_real);
         s1_im_abs <= abs_val(bus.src_imag);
      end
   end

   // A new sop outranks any beat of the abandoned frame still in stage 2.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         run_mag <= '0;
         run_bin <= PEAK_INIT;
      end else if (frame_start) begin
         run_mag <= '0;
         run_bin <= PEAK_INIT;
      end else if (peak_hit) begin
         run_mag <= mag;
         run_bin <= s1_bin;
      end
   end

   always_ff @(posedge Clk) begin
      if (s1_vld && stored) begin
         mem[s1_bin[AW-2:0]] <= mag;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= bus.rd_addr[AW-1] ? '0 : mem[bus.rd_addr[AW-2:0]];
         end
      end
   end
endmodule

// File: doc/fft_mag_peak.md
FFT_MAG_PEAK -- requirements
Module: fft_mag_peak

Interface
REQ-001 SHALL have parameter NPTS, default 1024, FFT frame length in points (power of two).
REQ-002 SHALL have parameter DW, default 8, signed width of FFT real/imag outputs.
REQ-003 SHALL have parameter SKIP_DC, default 1, 1 = bin 0 excluded from peak search.
REQ-004 SHALL have port Clk  input  1  single clock for all logic.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port src_valid  input  1  FFT source sample valid.
REQ-007 SHALL have port src_sop  input  1  first sample of frame.
REQ-008 SHALL have port src_eop  input  1  last sample of frame.
REQ-009 SHALL have port src_real  input  DW  signed real part.
REQ-010 SHALL have port src_imag  input  DW  signed imaginary part.
REQ-011 SHALL have port src_ready  output  1  drives FFT source_ready.
REQ-012 SHALL have port rd_en  input  1  spectrum buffer read strobe.
REQ-013 SHALL have port rd_addr  input  log2(NPTS)-1  bin index to read.
REQ-014 SHALL have port rd_data  output  DW+1  unsigned magnitude of addressed bin.
REQ-015 SHALL have port rd_valid  output  1  rd_data valid, one cycle.
REQ-016 SHALL have port peak_bin  output  log2(NPTS)-1  bin of largest magnitude, last good frame.
REQ-017 SHALL have port peak_mag  output  DW+1  magnitude at peak_bin.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse, good frame committed.
REQ-019 SHALL have port frame_err  output  1  one-cycle pulse, malformed frame discarded.

Function
REQ-020 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-021 IDLE: accepted beat (src_valid&src_ready) with src_sop -> CAPTURE, bin counter = 1, sample = bin 0; beats without sop ignored.
REQ-022 CAPTURE: each accepted beat increments bin counter; src_valid low stalls counter, no write.
REQ-023 SHALL compute mag = |src_real| + |src_imag| unsigned DW+1 bits; |-2^(DW-1)| = 2^(DW-1); no saturation needed (max 2^DW).
REQ-024 Pipeline: cycle 1 registers abs values, cycle 2 sums, writes buffer, updates running peak; write latency 2 cycles from accepted beat.
REQ-025 SHALL store only bins 0..NPTS/2-1; bins NPTS/2..NPTS-1 counted, not stored, not searched.
REQ-026 Running peak updates only on strictly greater mag; ties keep lower bin; bin 0 skipped when SKIP_DC=1.
REQ-027 src_eop on beat with index NPTS-1 -> DRAIN; DRAIN lasts 2 cycles, src_ready=0, then commits running peak to peak_bin/peak_mag, pulses frame_done, -> IDLE.
REQ-028 src_eop on index < NPTS-1, or index NPTS-1 without src_eop -> frame_err pulse, peak outputs unchanged, -> IDLE.
REQ-029 src_sop during CAPTURE -> frame_err pulse, current frame discarded, new frame starts with that beat as bin 0.
REQ-030 src_ready SHALL be 1 in IDLE and CAPTURE, 0 in DRAIN.
REQ-031 Read: rd_en at cycle N -> rd_data and rd_valid=1 at N+1; reads legal in any state; contents guaranteed stable only from frame_done until next accepted sop.
REQ-032 Running peak SHALL reset to mag 0 / bin 0 (bin 1 if SKIP_DC) on each sop.

Reset
REQ-033 Reset_n low SHALL asynchronously force IDLE, src_ready=1, rd_valid=0, rd_data=0, peak_bin=0, peak_mag=0, frame_done=0, frame_err=0, pipeline valids 0.
REQ-034 Buffer contents SHALL NOT be reset; reset mid-frame aborts without frame_done or frame_err.

Verification
REQ-035 Reset release -> all outputs 0, src_ready=1 on first cycle.
REQ-036 1024-beat frame, all zero except bin 37 re=-128 im=100 -> frame_done 3 cycles after eop beat, peak_bin=37, peak_mag=228; rd_addr=37 -> rd_data=228 next cycle.
REQ-037 Bins 10 and 20 both re=30 im=-20, rest 0 -> peak_bin=10, peak_mag=50.
REQ-038 SKIP_DC=1, bin 0 re=127 im=127, bin 5 re=3 im=0 -> peak_bin=5, peak_mag=3.
REQ-039 eop at index 500 after good frame -> frame_err pulse, no frame_done, peak outputs retain prior values.
REQ-040 Reset_n low at index 300, release, full good frame -> exactly one frame_done, peak from second frame only.
